// File: rtl/ltpi_dc_arbiter.sv
// LTPI data-channel arbiter: round-robin grant of one outstanding
// transaction among NUM_REQ requesters, with timeout and link-loss abort.
module ltpi_dc_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    parameter int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      link_aligned,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_error,
    output logic                      dc_req_valid,
    input  logic                      dc_req_ready,
    output logic                      dc_req_write,
    output logic [ADDR_W-1:0]         dc_req_addr,
    output logic [DATA_W-1:0]         dc_req_wdata,
    output logic [TAG_W-1:0]          dc_req_tag,
    input  logic                      dc_resp_valid,
    input  logic [DATA_W-1:0]         dc_resp_rdata,
    input  logic                      dc_resp_error,
    output logic                      busy,
    output logic                      timeout_evt
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_e;

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]    owner_q, owner_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rerr_q, rerr_d;
    logic                tevt_q, tevt_d;

    logic found;
    int   win;
    int   idx;
    logic tmo;

    assign tmo = (cnt_q == CNT_W'(TIMEOUT));

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = 0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        rvalid_d = '0;
        rdata_d  = '0;
        rerr_d   = 1'b0;
        tevt_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (link_aligned && found) begin
                    state_d = ISSUE;
                    owner_d = TAG_W'(win);
                    write_d = req_write[win];
                    addr_d  = req_addr[win*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[win*DATA_W +: DATA_W];
                    cnt_d   = '0;
                    ack_d   = NUM_REQ'(1) << win;
                end
            end
            ISSUE, WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the same cycle as an abort still completes.
                if (state_q == WAIT && dc_resp_valid) begin
                    state_d  = RESPOND;
                    rvalid_d = NUM_REQ'(1) << owner_q;
                    rdata_d  = dc_resp_rdata;
                    rerr_d   = dc_resp_error;
                end else if (!link_aligned) begin
                    state_d  = RESPOND;
                    rvalid_d = NUM_REQ'(1) << owner_q;
                    rerr_d   = 1'b1;
                end else if (tmo) begin
                    state_d  = RESPOND;
                    rvalid_d = NUM_REQ'(1) << owner_q;
                    rerr_d   = 1'b1;
                    tevt_d   = 1'b1;
                end else if (state_q == ISSUE && dc_req_ready) begin
                    state_d = WAIT;
                end
            end
            RESPOND: begin
                state_d  = IDLE;
                rr_ptr_d = (owner_q == TAG_W'(NUM_REQ - 1)) ? '0
                                                             : owner_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            tevt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            tevt_q   <= tevt_d;
        end
    end

    assign req_ack      = ack_q;
    assign resp_valid   = rvalid_q;
    assign resp_rdata   = rdata_q;
    assign resp_error   = rerr_q;
    assign timeout_evt  = tevt_q;
    assign busy         = (state_q != IDLE);
    assign dc_req_valid = (state_q == ISSUE) && !tmo;
    assign dc_req_write = write_q;
    assign dc_req_addr  = addr_q;
    assign dc_req_wdata = wdata_q;
    assign dc_req_tag   = owner_q;

endmodule

// File: tb/tb_ltpi_dc_arbiter.sv
// Self-checking bench for ltpi_dc_arbiter: directed scenarios plus
// randomized transactions against a round-robin reference model.
module tb_ltpi_dc_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          link_aligned = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]  req_ack;
    logic [N-1:0]  resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_error;
    logic          dc_req_valid;
    logic          dc_req_ready = 1'b0;
    logic          dc_req_write;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_wdata;
    logic [1:0]    dc_req_tag;
    logic          dc_resp_valid = 1'b0;
    logic [DW-1:0] dc_resp_rdata = '0;
    logic          dc_resp_error = 1'b0;
    logic          busy;
    logic          timeout_evt;

    int checks = 0;
    int errors = 0;
    int exp_ptr = 0;
    int hs_cnt = 0;

    logic [94:0] all_out;
    assign all_out = {busy, req_ack, resp_valid, resp_rdata, resp_error,
                      dc_req_valid, dc_req_write, dc_req_addr,
                      dc_req_wdata, dc_req_tag, timeout_evt};

    ltpi_dc_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .link_aligned(link_aligned),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_write(dc_req_write), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_tag(dc_req_tag),
        .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
        .dc_resp_error(dc_resp_error), .busy(busy),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (dc_req_valid && dc_req_ready) hs_cnt <= hs_cnt + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: lowest set index at or above p, else lowest below p.
    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int j = p; j < N; j++) if (m[j]) return j;
        for (int j = 0; j < p; j++) if (m[j]) return j;
        return -1;
    endfunction

    task automatic rand_fields;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = AW'($urandom);
            req_wdata[i*DW +: DW] = $urandom;
        end
        req_write = N'($urandom);
    endtask

    task automatic apply_reset;
        req_valid = '0;
        dc_req_ready = 1'b0;
        dc_resp_valid = 1'b0;
        link_aligned = 1'b1;
        reset_n = 1'b0;
        tick;
        tick;
        reset_n = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outs got %h exp 0", all_out);
        end
        tick;
        tick;
        reset_n = 1'b1;
        exp_ptr = 0;
        tick;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL post_reset_idle got %h exp 0", all_out);
        end
    endtask

    task automatic test_single_read;
        req_addr[0 +: AW] = 16'h0010;
        req_write[0] = 1'b0;
        req_valid = 4'b0001;
        dc_req_ready = 1'b1;
        tick;
        checks++;
        if (req_ack !== 4'b0001 || dc_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL sr_ack got %b/%b exp 0001/1",
                     req_ack, dc_req_valid);
        end
        checks++;
        if (dc_req_tag !== 2'd0 || dc_req_addr !== 16'h0010 ||
            dc_req_write !== 1'b0) begin
            errors++;
            $display("FAIL sr_fields got tag %0d addr %h wr %b exp 0 0010 0",
                     dc_req_tag, dc_req_addr, dc_req_write);
        end
        req_valid = '0;
        tick;
        dc_resp_valid = 1'b1;
        dc_resp_rdata = 32'hDEADBEEF;
        dc_resp_error = 1'b0;
        tick;
        dc_resp_valid = 1'b0;
        checks++;
        if (resp_valid !== 4'b0001 || resp_rdata !== 32'hDEADBEEF ||
            resp_error !== 1'b0) begin
            errors++;
            $display("FAIL sr_resp got %b %h %b exp 0001 deadbeef 0",
                     resp_valid, resp_rdata, resp_error);
        end
        tick;
        checks++;
        if (busy !== 1'b0 || resp_valid !== '0) begin
            errors++;
            $display("FAIL sr_idle got busy %b rv %b exp 0 0",
                     busy, resp_valid);
        end
        exp_ptr = 1;
    endtask

    task automatic test_round_robin;
        int acks [N];
        int w;
        logic [DW-1:0] rd;
        apply_reset;
        for (int i = 0; i < N; i++) acks[i] = 0;
        rand_fields;
        req_valid = 4'hF;
        dc_req_ready = 1'b1;
        for (int t = 0; t < 2 * N; t++) begin
            w = rr_pick(req_valid, exp_ptr);
            tick;
            for (int i = 0; i < N; i++) if (req_ack[i]) acks[i]++;
            checks++;
            if (dc_req_tag !== 2'(t % N) || req_ack !== (4'b1 << (t % N))) begin
                errors++;
                $display("FAIL rr_order got tag %0d ack %b exp %0d",
                         dc_req_tag, req_ack, t % N);
            end
            checks++;
            if (dc_req_addr !== req_addr[w*AW +: AW] ||
                dc_req_wdata !== req_wdata[w*DW +: DW] ||
                dc_req_write !== req_write[w]) begin
                errors++;
                $display("FAIL rr_fields got %h %h %b exp %h %h %b",
                         dc_req_addr, dc_req_wdata, dc_req_write,
                         req_addr[w*AW +: AW], req_wdata[w*DW +: DW],
                         req_write[w]);
            end
            tick;
            rd = $urandom;
            dc_resp_valid = 1'b1;
            dc_resp_rdata = rd;
            dc_resp_error = 1'b0;
            tick;
            dc_resp_valid = 1'b0;
            checks++;
            if (resp_valid !== (4'b1 << w) || resp_rdata !== rd) begin
                errors++;
                $display("FAIL rr_resp got %b %h exp %b %h",
                         resp_valid, resp_rdata, 4'b1 << w, rd);
            end
            tick;
            exp_ptr = (w + 1) % N;
            rand_fields;
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (acks[i] !== 2) begin
                errors++;
                $display("FAIL rr_ack_count req %0d got %0d exp 2", i, acks[i]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        int r;
        int h0;
        logic [50:0] snap;
        logic [DW-1:0] rd;
        r = $urandom_range(0, N - 1);
        rand_fields;
        req_valid = 4'b1 << r;
        dc_req_ready = 1'b0;
        h0 = hs_cnt;
        tick;
        checks++;
        if (req_ack !== (4'b1 << r)) begin
            errors++;
            $display("FAIL bp_ack got %b exp %b", req_ack, 4'b1 << r);
        end
        snap = {req_write[r], req_addr[r*AW +: AW], 2'(r)};
        snap = {snap[18:0], 32'h0} | {19'h0, req_wdata[r*DW +: DW]};
        req_valid = '0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dc_req_valid !== 1'b1 ||
                {dc_req_write, dc_req_addr, dc_req_tag, dc_req_wdata}
                !== snap) begin
                errors++;
                $display("FAIL bp_stable cyc %0d got %b %h exp 1 %h", i,
                         dc_req_valid,
                         {dc_req_write, dc_req_addr, dc_req_tag, dc_req_wdata},
                         snap);
            end
            if (i == 7) dc_req_ready = 1'b1;
            tick;
        end
        checks++;
        if (dc_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_wait_valid got %b exp 0", dc_req_valid);
        end
        rd = $urandom;
        dc_resp_valid = 1'b1;
        dc_resp_rdata = rd;
        dc_resp_error = 1'b1;
        tick;
        dc_resp_valid = 1'b0;
        checks++;
        if (resp_valid !== (4'b1 << r) || resp_rdata !== rd ||
            resp_error !== 1'b1) begin
            errors++;
            $display("FAIL bp_resp got %b %h %b exp %b %h 1",
                     resp_valid, resp_rdata, resp_error, 4'b1 << r, rd);
        end
        tick;
        checks++;
        if (hs_cnt - h0 !== 1) begin
            errors++;
            $display("FAIL bp_handshakes got %0d exp 1", hs_cnt - h0);
        end
        exp_ptr = (r + 1) % N;
        dc_req_ready = 1'b0;
    endtask

    task automatic test_timeout;
        int r;
        int seen;
        int extra;
        r = $urandom_range(0, N - 1);
        rand_fields;
        req_valid = 4'b1 << r;
        dc_req_ready = 1'b1;
        tick;
        req_valid = '0;
        seen = 0;
        for (int c = 2; c <= 40; c++) begin
            tick;
            if (resp_valid !== '0) begin
                seen = c;
                break;
            end
        end
        checks++;
        if (seen !== TO + 2) begin
            errors++;
            $display("FAIL to_latency got cycle %0d exp %0d", seen, TO + 2);
        end
        checks++;
        if (resp_valid !== (4'b1 << r) || resp_error !== 1'b1 ||
            resp_rdata !== '0 || timeout_evt !== 1'b1) begin
            errors++;
            $display("FAIL to_resp got %b err %b data %h evt %b exp %b 1 0 1",
                     resp_valid, resp_error, resp_rdata, timeout_evt,
                     4'b1 << r);
        end
        tick;
        checks++;
        if (timeout_evt !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_after got evt %b busy %b exp 0 0",
                     timeout_evt, busy);
        end
        exp_ptr = (r + 1) % N;
        repeat (4) tick;
        dc_resp_valid = 1'b1;
        dc_resp_rdata = $urandom;
        dc_resp_error = 1'b0;
        tick;
        dc_resp_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid !== '0 || busy !== 1'b0) extra++;
            tick;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL to_late_resp got %0d spurious cycles exp 0", extra);
        end
    endtask

    task automatic test_link_loss;
        int r;
        int bad;
        logic [DW-1:0] rd;
        logic er;
        r = $urandom_range(0, 2);
        if (r == 2) r = 3;
        rand_fields;
        req_valid = 4'b1 << r;
        dc_req_ready = 1'b1;
        tick;
        req_valid = 4'b0100;
        tick;
        link_aligned = 1'b0;
        tick;
        checks++;
        if (resp_valid !== (4'b1 << r) || resp_error !== 1'b1 ||
            resp_rdata !== '0 || timeout_evt !== 1'b0) begin
            errors++;
            $display("FAIL ll_resp got %b err %b data %h evt %b exp %b 1 0 0",
                     resp_valid, resp_error, resp_rdata, timeout_evt,
                     4'b1 << r);
        end
        exp_ptr = (r + 1) % N;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (req_ack !== '0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ll_no_grant got %0d grant cycles exp 0", bad);
        end
        link_aligned = 1'b1;
        tick;
        checks++;
        if (req_ack !== 4'b0100 || dc_req_tag !== 2'd2 ||
            dc_req_addr !== req_addr[2*AW +: AW]) begin
            errors++;
            $display("FAIL ll_regrant got %b tag %0d addr %h exp 0100 2 %h",
                     req_ack, dc_req_tag, dc_req_addr, req_addr[2*AW +: AW]);
        end
        req_valid = '0;
        tick;
        rd = $urandom;
        er = 1'($urandom);
        dc_resp_valid = 1'b1;
        dc_resp_rdata = rd;
        dc_resp_error = er;
        tick;
        dc_resp_valid = 1'b0;
        checks++;
        if (resp_valid !== 4'b0100 || resp_rdata !== rd || resp_error !== er) begin
            errors++;
            $display("FAIL ll_resp2 got %b %h %b exp 0100 %h %b",
                     resp_valid, resp_rdata, resp_error, rd, er);
        end
        tick;
        exp_ptr = 3;
    endtask

    task automatic test_reset_mid_wait;
        int r;
        logic [DW-1:0] rd;
        r = $urandom_range(0, N - 1);
        rand_fields;
        req_valid = 4'b1 << r;
        dc_req_ready = 1'b1;
        tick;
        req_valid = '0;
        tick;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rw_busy got %b exp 1", busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rw_outs got %h exp 0", all_out);
        end
        dc_resp_valid = 1'b1;
        tick;
        tick;
        dc_resp_valid = 1'b0;
        reset_n = 1'b1;
        exp_ptr = 0;
        req_valid = 4'b1010;
        tick;
        checks++;
        if (req_ack !== (4'b1 << rr_pick(4'b1010, exp_ptr)) ||
            dc_req_tag !== 2'd1) begin
            errors++;
            $display("FAIL rw_first got %b tag %0d exp 0010 1",
                     req_ack, dc_req_tag);
        end
        req_valid = 4'b1000;
        tick;
        rd = $urandom;
        dc_resp_valid = 1'b1;
        dc_resp_rdata = rd;
        dc_resp_error = 1'b0;
        tick;
        dc_resp_valid = 1'b0;
        checks++;
        if (resp_valid !== 4'b0010 || resp_rdata !== rd) begin
            errors++;
            $display("FAIL rw_resp got %b %h exp 0010 %h",
                     resp_valid, resp_rdata, rd);
        end
        tick;
        exp_ptr = 2;
        tick;
        checks++;
        if (req_ack !== 4'b1000) begin
            errors++;
            $display("FAIL rw_second got %b exp 1000", req_ack);
        end
        req_valid = '0;
        tick;
        dc_resp_valid = 1'b1;
        tick;
        dc_resp_valid = 1'b0;
        tick;
        exp_ptr = 0;
    endtask

    task automatic test_random;
        logic [N-1:0] m;
        int w;
        int d;
        int e;
        logic [DW-1:0] rd;
        logic er;
        for (int t = 0; t < 30; t++) begin
            m = N'($urandom_range(1, 15));
            rand_fields;
            req_valid = m;
            w = rr_pick(m, exp_ptr);
            d = $urandom_range(0, 3);
            e = $urandom_range(0, 3);
            tick;
            checks++;
            if (req_ack !== (4'b1 << w) || dc_req_tag !== 2'(w) ||
                dc_req_addr !== req_addr[w*AW +: AW] ||
                dc_req_wdata !== req_wdata[w*DW +: DW] ||
                dc_req_write !== req_write[w]) begin
                errors++;
                $display("FAIL rnd_grant t %0d mask %b got ack %b tag %0d exp %0d",
                         t, m, req_ack, dc_req_tag, w);
            end
            req_valid = '0;
            dc_req_ready = 1'b0;
            for (int i = 0; i < d; i++) begin
                tick;
                checks++;
                if (dc_req_valid !== 1'b1 || dc_req_tag !== 2'(w)) begin
                    errors++;
                    $display("FAIL rnd_hold got %b tag %0d exp 1 %0d",
                             dc_req_valid, dc_req_tag, w);
                end
            end
            dc_req_ready = 1'b1;
            tick;
            dc_req_ready = 1'b0;
            for (int i = 0; i < e; i++) begin
                tick;
                checks++;
                if (resp_valid !== '0) begin
                    errors++;
                    $display("FAIL rnd_early_resp got %b exp 0", resp_valid);
                end
            end
            rd = $urandom;
            er = 1'($urandom);
            dc_resp_valid = 1'b1;
            dc_resp_rdata = rd;
            dc_resp_error = er;
            tick;
            dc_resp_valid = 1'b0;
            checks++;
            if (resp_valid !== (4'b1 << w) || resp_rdata !== rd ||
                resp_error !== er) begin
                errors++;
                $display("FAIL rnd_resp got %b %h %b exp %b %h %b",
                         resp_valid, resp_rdata, resp_error, 4'b1 << w, rd, er);
            end
            tick;
            exp_ptr = (w + 1) % N;
        end
    endtask

    initial begin
        #2;
        test_reset;
        test_single_read;
        test_round_robin;
        test_backpressure;
        test_timeout;
        test_link_loss;
        test_reset_mid_wait;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
